// File: rtl/tri_raster_scan_pkg.sv
// Shared types and helpers for the triangle raster scan front end:
// point/triangle payloads, FSM states, edge function and bbox arithmetic.
package tri_raster_scan_pkg;

  localparam int unsigned COORD_W       = 32;
  localparam int unsigned DEN_W         = 31;
  localparam int unsigned FRAC_BITS_DEF = 16;
  localparam int unsigned SCREEN_W_DEF  = 640;
  localparam int unsigned SCREEN_H_DEF  = 480;

  typedef struct packed {
    logic signed [COORD_W-1:0] x;
    logic signed [COORD_W-1:0] y;
  } int_point;

  typedef struct packed {
    int_point a;
    int_point b;
    int_point c;
  } int_triangle;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETUP,
    ST_DIV,
    ST_SCAN
  } rs_state_e;

  // Signed doubled area; the sign gives the winding order.
  function automatic logic signed [COORD_W-1:0] edge_fn(input int_point a, input int_point b,
                                                        input int_point c);
    return (b.x - a.x) * (c.y - a.y) - (b.y - a.y) * (c.x - a.x);
  endfunction

  function automatic logic signed [COORD_W-1:0] min3(input logic signed [COORD_W-1:0] a,
                                                     input logic signed [COORD_W-1:0] b,
                                                     input logic signed [COORD_W-1:0] c);
    logic signed [COORD_W-1:0] m;
    m = (a < b) ? a : b;
    return (m < c) ? m : c;
  endfunction

  function automatic logic signed [COORD_W-1:0] max3(input logic signed [COORD_W-1:0] a,
                                                     input logic signed [COORD_W-1:0] b,
                                                     input logic signed [COORD_W-1:0] c);
    logic signed [COORD_W-1:0] m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  function automatic logic signed [COORD_W-1:0] clamp(input logic signed [COORD_W-1:0] v,
                                                      input logic signed [COORD_W-1:0] hi);
    if (v < 32'sd0) return '0;
    if (v > hi) return hi;
    return v;
  endfunction

endpackage

// File: rtl/tri_raster_scan_recip_div.sv
// Iterative restoring divider computing (1<<FRAC_BITS)/den, one quotient bit
// per cycle MSB first; done_o pulses for one cycle when quot_o is final.
module recip_div
  import tri_raster_scan_pkg::*;
#(
  parameter int unsigned FRAC_BITS = FRAC_BITS_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start_i,
  input  logic [DEN_W-1:0]     den_i,
  output logic                 done_o,
  output logic [FRAC_BITS:0]   quot_o
);

  localparam int unsigned QW    = FRAC_BITS + 1;
  localparam int unsigned REM_W = DEN_W + FRAC_BITS + 2;
  localparam int unsigned SH_W  = REM_W + 1;
  localparam int unsigned CNT_W = $clog2(QW + 1);

  logic [REM_W-1:0] rem_q, rem_d;
  logic [QW-1:0]    num_q, num_d;
  logic [QW-1:0]    quot_q, quot_d;
  logic [DEN_W-1:0] den_q, den_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             done_q, done_d;

  logic [SH_W-1:0]  rem_sh;
  logic [SH_W-1:0]  rem_sub;
  logic             ge;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rem_q  <= '0;
      num_q  <= '0;
      quot_q <= '0;
      den_q  <= '0;
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else begin
      rem_q  <= rem_d;
      num_q  <= num_d;
      quot_q <= quot_d;
      den_q  <= den_d;
      cnt_q  <= cnt_d;
      done_q <= done_d;
    end
  end

  // Shift in the next dividend bit, subtract the divisor when it fits.
  always_comb begin
    rem_d   = rem_q;
    num_d   = num_q;
    quot_d  = quot_q;
    den_d   = den_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    rem_sh  = {rem_q, num_q[QW-1]};
    ge      = (rem_sh >= SH_W'(den_q));
    rem_sub = rem_sh - SH_W'(den_q);
    if (start_i) begin
      rem_d  = '0;
      num_d  = {1'b1, {FRAC_BITS{1'b0}}};
      quot_d = '0;
      den_d  = den_i;
      cnt_d  = CNT_W'(QW);
    end else if (cnt_q != '0) begin
      rem_d  = REM_W'(ge ? rem_sub : rem_sh);
      quot_d = {quot_q[QW-2:0], ge};
      num_d  = num_q << 1;
      cnt_d  = cnt_q - CNT_W'(1);
      done_d = (cnt_q == CNT_W'(1));
    end
  end

  assign done_o = done_q;
  assign quot_o = quot_q;

endmodule

// File: rtl/tri_raster_scan.sv
// Accepts one triangle, computes its clamped bbox and fixed-point reciprocal
// area, then streams every pixel of the box in row-major order.
module tri_raster_scan
  import tri_raster_scan_pkg::*;
#(
  parameter int unsigned SCREEN_W  = SCREEN_W_DEF,
  parameter int unsigned SCREEN_H  = SCREEN_H_DEF,
  parameter int unsigned FRAC_BITS = FRAC_BITS_DEF
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      tri_valid,
  output logic                      tri_ready,
  input  int_triangle               in_tri,
  output logic                      pt_valid,
  input  logic                      pt_ready,
  output int_triangle               out_tri,
  output int_point                  out_point,
  output logic signed [COORD_W-1:0] inv_tri_edge_fn,
  output logic                      pt_last,
  output logic                      busy
);

  localparam logic signed [COORD_W-1:0] X_LIM = COORD_W'(SCREEN_W - 1);
  localparam logic signed [COORD_W-1:0] Y_LIM = COORD_W'(SCREEN_H - 1);

  rs_state_e                 state_q, state_d;
  int_triangle               tri_q, tri_d;
  logic signed [COORD_W-1:0] xmin_q, xmin_d, xmax_q, xmax_d;
  logic signed [COORD_W-1:0] ymin_q, ymin_d, ymax_q, ymax_d;
  logic signed [COORD_W-1:0] x_q, x_d, y_q, y_d;
  logic signed [COORD_W-1:0] inv_q, inv_d;
  logic                      neg_q, neg_d;

  logic signed [COORD_W-1:0] area_c;
  logic signed [COORD_W-1:0] lo_x_c, hi_x_c, lo_y_c, hi_y_c;
  logic signed [COORD_W-1:0] quot_c;
  logic                      reject_c;
  logic                      div_start_c;
  logic [DEN_W-1:0]          div_den_c;
  logic                      div_done;
  logic [FRAC_BITS:0]        div_quot;

  recip_div #(
    .FRAC_BITS (FRAC_BITS)
  ) u_recip_div (
    .clk     (clk),
    .rst     (rst),
    .start_i (div_start_c),
    .den_i   (div_den_c),
    .done_o  (div_done),
    .quot_o  (div_quot)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      tri_q   <= '0;
      xmin_q  <= '0;
      xmax_q  <= '0;
      ymin_q  <= '0;
      ymax_q  <= '0;
      x_q     <= '0;
      y_q     <= '0;
      inv_q   <= '0;
      neg_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      tri_q   <= tri_d;
      xmin_q  <= xmin_d;
      xmax_q  <= xmax_d;
      ymin_q  <= ymin_d;
      ymax_q  <= ymax_d;
      x_q     <= x_d;
      y_q     <= y_d;
      inv_q   <= inv_d;
      neg_q   <= neg_d;
    end
  end

  // Setup arithmetic on the latched triangle; only consumed in ST_SETUP.
  always_comb begin
    area_c    = edge_fn(tri_q.a, tri_q.b, tri_q.c);
    lo_x_c    = min3(tri_q.a.x, tri_q.b.x, tri_q.c.x);
    hi_x_c    = max3(tri_q.a.x, tri_q.b.x, tri_q.c.x);
    lo_y_c    = min3(tri_q.a.y, tri_q.b.y, tri_q.c.y);
    hi_y_c    = max3(tri_q.a.y, tri_q.b.y, tri_q.c.y);
    reject_c  = (area_c == '0) || (hi_x_c < 32'sd0) || (lo_x_c > X_LIM) ||
                (hi_y_c < 32'sd0) || (lo_y_c > Y_LIM);
    div_den_c = (area_c < 32'sd0) ? DEN_W'(-area_c) : DEN_W'(area_c);
    quot_c    = COORD_W'(div_quot);
  end

  always_comb begin
    state_d     = state_q;
    tri_d       = tri_q;
    xmin_d      = xmin_q;
    xmax_d      = xmax_q;
    ymin_d      = ymin_q;
    ymax_d      = ymax_q;
    x_d         = x_q;
    y_d         = y_q;
    inv_d       = inv_q;
    neg_d       = neg_q;
    div_start_c = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (tri_valid) begin
          tri_d   = in_tri;
          state_d = ST_SETUP;
        end
      end
      ST_SETUP: begin
        xmin_d = clamp(lo_x_c, X_LIM);
        xmax_d = clamp(hi_x_c, X_LIM);
        ymin_d = clamp(lo_y_c, Y_LIM);
        ymax_d = clamp(hi_y_c, Y_LIM);
        neg_d  = (area_c < 32'sd0);
        if (reject_c) begin
          state_d = ST_IDLE;
        end else begin
          div_start_c = 1'b1;
          state_d     = ST_DIV;
        end
      end
      ST_DIV: begin
        if (div_done) begin
          inv_d   = neg_q ? -quot_c : quot_c;
          x_d     = xmin_q;
          y_d     = ymin_q;
          state_d = ST_SCAN;
        end
      end
      ST_SCAN: begin
        if (pt_ready) begin
          if (x_q < xmax_q) begin
            x_d = x_q + 32'sd1;
          end else if (y_q < ymax_q) begin
            x_d = xmin_q;
            y_d = y_q + 32'sd1;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign tri_ready       = (state_q == ST_IDLE);
  assign busy            = (state_q != ST_IDLE);
  assign pt_valid        = (state_q == ST_SCAN);
  assign pt_last         = (state_q == ST_SCAN) && (x_q == xmax_q) && (y_q == ymax_q);
  assign out_tri         = tri_q;
  assign out_point       = '{x: x_q, y: y_q};
  assign inv_tri_edge_fn = inv_q;

endmodule

// File: tb/tb_tri_raster_scan.sv
// Directed plus randomized bench for tri_raster_scan, checked against a
// plain-arithmetic model of bbox, reciprocal area and row-major pixel order.
module tb_tri_raster_scan;
  import tri_raster_scan_pkg::*;

  logic               clk = 1'b0;
  logic               rst;
  logic               tri_valid;
  logic               tri_ready;
  int_triangle        in_tri;
  logic               pt_valid;
  logic               pt_ready;
  int_triangle        out_tri;
  int_point           out_point;
  logic signed [31:0] inv_tri_edge_fn;
  logic               pt_last;
  logic               busy;

  int n_checks  = 0;
  int n_err     = 0;
  int cyc       = 0;
  int last_xfer = 0;

  tri_raster_scan #(
    .SCREEN_W  (640),
    .SCREEN_H  (480),
    .FRAC_BITS (16)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .tri_valid       (tri_valid),
    .tri_ready       (tri_ready),
    .in_tri          (in_tri),
    .pt_valid        (pt_valid),
    .pt_ready        (pt_ready),
    .out_tri         (out_tri),
    .out_point       (out_point),
    .inv_tri_edge_fn (inv_tri_edge_fn),
    .pt_last         (pt_last),
    .busy            (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input longint obs, input longint exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int_triangle mk_tri(input int ax, input int ay, input int bx,
                                         input int by, input int cx, input int cy);
    int_triangle t;
    t.a.x = ax; t.a.y = ay;
    t.b.x = bx; t.b.y = by;
    t.c.x = cx; t.c.y = cy;
    return t;
  endfunction

  function automatic longint lmin(input longint a, input longint b);
    return (a < b) ? a : b;
  endfunction

  function automatic longint lmax(input longint a, input longint b);
    return (a > b) ? a : b;
  endfunction

  // Called at a negedge: assert reset, check reset values, release at the next negedge.
  task automatic do_reset();
    rst       = 1'b1;
    tri_valid = 1'b0;
    #1;
    chk("rst_pt_valid", pt_valid, 0);
    chk("rst_pt_last", pt_last, 0);
    chk("rst_busy", busy, 0);
    chk("rst_tri_ready", tri_ready, 1);
    chk("rst_out_tri_zero", (out_tri === '0), 1);
    chk("rst_point_x", out_point.x, 0);
    chk("rst_point_y", out_point.y, 0);
    chk("rst_inv", inv_tri_edge_fn, 0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Called at a negedge. Presents t, follows it through to the end (or an abort).
  task automatic process_tri(input int_triangle t, input bit bp, input int abort_div,
                             input int abort_after, input bit keep_valid,
                             input int_triangle nxt, input bit chk_b2b);
    longint   area, xmn, xmx, ymn, ymx, mag, q, einv;
    bit       reject;
    int_point exp_q[$];
    int_point p, prev_p;
    int       acc, guard, nxf;
    bit       stall_prev, prev_last;
    longint   prev_inv;

    area = (longint'(t.b.x) - t.a.x) * (longint'(t.c.y) - t.a.y)
         - (longint'(t.b.y) - t.a.y) * (longint'(t.c.x) - t.a.x);
    xmn = lmin(lmin(t.a.x, t.b.x), t.c.x);
    xmx = lmax(lmax(t.a.x, t.b.x), t.c.x);
    ymn = lmin(lmin(t.a.y, t.b.y), t.c.y);
    ymx = lmax(lmax(t.a.y, t.b.y), t.c.y);
    reject = (area == 0) || (xmx < 0) || (xmn > 639) || (ymx < 0) || (ymn > 479);
    xmn = lmin(lmax(xmn, 0), 639);
    xmx = lmin(lmax(xmx, 0), 639);
    ymn = lmin(lmax(ymn, 0), 479);
    ymx = lmin(lmax(ymx, 0), 479);
    if (!reject)
      for (longint yy = ymn; yy <= ymx; yy++)
        for (longint xx = xmn; xx <= xmx; xx++) begin
          p.x = 32'(xx);
          p.y = 32'(yy);
          exp_q.push_back(p);
        end
    mag  = (area < 0) ? -area : area;
    q    = (mag != 0) ? (64'sd65536 / mag) : 0;
    einv = (area < 0) ? -q : q;

    tri_valid = 1'b1;
    in_tri    = t;
    guard     = 0;
    while (!tri_ready && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
    chk("accept_ready", tri_ready, 1);
    acc = cyc + 1;
    if (chk_b2b) chk("b2b_accept_edge", acc, last_xfer + 1);
    @(negedge clk);
    if (keep_valid) in_tri = nxt;
    else tri_valid = 1'b0;
    chk("setup_busy", busy, 1);
    chk("setup_tri_ready", tri_ready, 0);
    chk("out_tri_latched", (out_tri === t), 1);

    if (reject) begin
      @(negedge clk);
      chk("reject_tri_ready", tri_ready, 1);
      chk("reject_busy", busy, 0);
      for (int i = 0; i < 3; i++) begin
        @(negedge clk);
        chk("reject_no_point", pt_valid, 0);
      end
      return;
    end

    if (abort_div > 0) begin
      repeat (abort_div) @(negedge clk);
      chk("div_busy", busy, 1);
      chk("div_no_point", pt_valid, 0);
      do_reset();
      return;
    end

    guard = 0;
    while (!pt_valid && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    chk("first_pt_latency", cyc - acc, 19);

    nxf        = 0;
    stall_prev = 1'b0;
    guard      = 0;
    while (guard < 5000) begin
      guard++;
      if (!pt_valid) begin
        chk("pt_valid_held", pt_valid, 1);
        break;
      end
      if (stall_prev) begin
        chk("stall_x", out_point.x, prev_p.x);
        chk("stall_y", out_point.y, prev_p.y);
        chk("stall_inv", inv_tri_edge_fn, prev_inv);
        chk("stall_last", pt_last, prev_last);
      end
      chk("pt_x", out_point.x, exp_q[0].x);
      chk("pt_y", out_point.y, exp_q[0].y);
      chk("pt_last", pt_last, (exp_q.size() == 1) ? 1 : 0);
      chk("inv", inv_tri_edge_fn, einv);
      pt_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      if (pt_ready) begin
        void'(exp_q.pop_front());
        nxf++;
        stall_prev = 1'b0;
        if (exp_q.size() == 0) begin
          last_xfer = cyc + 1;
          @(negedge clk);
          break;
        end
        if (nxf == abort_after) begin
          @(negedge clk);
          do_reset();
          return;
        end
      end else begin
        stall_prev = 1'b1;
        prev_p     = out_point;
        prev_inv   = inv_tri_edge_fn;
        prev_last  = pt_last;
      end
      @(negedge clk);
    end
    chk("points_remaining", exp_q.size(), 0);
    chk("done_pt_valid", pt_valid, 0);
    chk("done_tri_ready", tri_ready, 1);
    pt_ready = 1'b1;
  endtask

  int_triangle t_a, t_col, t_clamp, t_off, t_rnd;
  int          bx0, by0, reg_sel;

  initial begin
    rst       = 1'b1;
    tri_valid = 1'b0;
    pt_ready  = 1'b1;
    in_tri    = '0;
    t_a       = mk_tri(0, 0, 4, 0, 0, 4);
    t_col     = mk_tri(0, 0, 2, 2, 5, 5);
    t_clamp   = mk_tri(-3, -3, 2, -3, -3, 1);
    t_off     = mk_tri(700, 10, 710, 10, 700, 20);

    #2;
    chk("init_tri_ready", tri_ready, 1);
    chk("init_busy", busy, 0);
    chk("init_pt_valid", pt_valid, 0);
    chk("init_inv", inv_tri_edge_fn, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    process_tri(t_a, 1'b0, 0, 0, 1'b0, t_a, 1'b0);
    process_tri(t_col, 1'b0, 0, 0, 1'b0, t_col, 1'b0);
    process_tri(t_clamp, 1'b0, 0, 0, 1'b0, t_clamp, 1'b0);
    process_tri(t_off, 1'b0, 0, 0, 1'b0, t_off, 1'b0);
    process_tri(t_a, 1'b1, 0, 0, 1'b0, t_a, 1'b0);
    process_tri(mk_tri(0, 0, 0, 4, 4, 0), 1'b1, 0, 0, 1'b0, t_a, 1'b0);
    process_tri(mk_tri(5, 5, 5, 6, 6, 5), 1'b0, 0, 0, 1'b0, t_a, 1'b0);
    process_tri(mk_tri(639, 479, 650, 479, 639, 490), 1'b0, 0, 0, 1'b0, t_a, 1'b0);

    process_tri(t_a, 1'b0, 5, 0, 1'b0, t_a, 1'b0);
    process_tri(t_clamp, 1'b0, 0, 0, 1'b0, t_clamp, 1'b0);
    process_tri(t_a, 1'b0, 0, 10, 1'b0, t_a, 1'b0);
    process_tri(t_a, 1'b1, 0, 0, 1'b0, t_a, 1'b0);

    process_tri(t_a, 1'b0, 0, 0, 1'b1, t_clamp, 1'b0);
    process_tri(t_clamp, 1'b0, 0, 0, 1'b0, t_clamp, 1'b1);

    for (int k = 0; k < 10; k++) begin
      reg_sel = int'($urandom_range(0, 2));
      bx0 = (reg_sel == 0) ? -6 : (reg_sel == 1) ? 632 : 300;
      by0 = (reg_sel == 0) ? -6 : (reg_sel == 1) ? 472 : 200;
      t_rnd = mk_tri(bx0 + int'($urandom_range(0, 12)), by0 + int'($urandom_range(0, 12)),
                     bx0 + int'($urandom_range(0, 12)), by0 + int'($urandom_range(0, 12)),
                     bx0 + int'($urandom_range(0, 12)), by0 + int'($urandom_range(0, 12)));
      process_tri(t_rnd, 1'($urandom_range(0, 1)), 0, 0, 1'b0, t_rnd, 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

endmodule
